// File: rtl/vsu_pkg.sv
// -----------------------------------------------------------------------------
// vsu_pkg -- shared types and helpers for the vector store unit.
//
// Contents:
//   vsu_state_e : controller states (IDLE, WRITE, DONE)
//   vsu_beats   : number of BRAM beats per store (elements / lanes)
//   vsu_cnt_w   : beat-counter width; the counter must also hold the value
//                 BEATS, which marks "every beat has been issued"
// -----------------------------------------------------------------------------
package vsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } vsu_state_e;

  // NO_OF_ELEM must be a whole multiple of LANES.
  function automatic int vsu_beats(input int n_elem, input int lanes);
    return n_elem / lanes;
  endfunction

  function automatic int vsu_cnt_w(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/vec_store_unit_if.sv
// -----------------------------------------------------------------------------
// vec_store_unit_if -- request and BRAM-write bundle of the vector store unit.
//
// Request side : start, stall, dataIn, baseAddr, stride, elemMask (only when
//                VSU_MASK_EN is defined)
// BRAM side    : dataOut, writeAddrBRAM, writeEN, laneWE, busy, WRdone
//
// Modports: slave  -- the store unit itself
//           master -- whoever issues stores and consumes the BRAM writes
// -----------------------------------------------------------------------------
interface vec_store_unit_if #(
  parameter int NO_OF_ELEM = 16,
  parameter int WORD_SIZE  = 32,
  parameter int MEM_DEPTH  = 9,
  parameter int LANES      = 1
);

  logic                            start;
  logic                            stall;
  logic [NO_OF_ELEM*WORD_SIZE-1:0] dataIn;
  logic [MEM_DEPTH-1:0]            baseAddr;
  logic [MEM_DEPTH-1:0]            stride;
`ifdef VSU_MASK_EN
  logic [NO_OF_ELEM-1:0]           elemMask;
`endif
  logic [LANES*WORD_SIZE-1:0]      dataOut;
  logic [MEM_DEPTH-1:0]            writeAddrBRAM;
  logic                            writeEN;
  logic [LANES-1:0]                laneWE;
  logic                            busy;
  logic                            WRdone;

  modport slave (
`ifdef VSU_MASK_EN
    input  elemMask,
`endif
    input  start, stall, dataIn, baseAddr, stride,
    output dataOut, writeAddrBRAM, writeEN, laneWE, busy, WRdone
  );

  modport master (
`ifdef VSU_MASK_EN
    output elemMask,
`endif
    output start, stall, dataIn, baseAddr, stride,
    input  dataOut, writeAddrBRAM, writeEN, laneWE, busy, WRdone
  );

endinterface

// File: rtl/vsu_addr_gen.sv
// -----------------------------------------------------------------------------
// vsu_addr_gen -- base/stride address accumulator for the vector store unit.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : start of a store; captures stride, preloads base + stride
//   step_i     : a beat was issued; advance by the captured stride
//   base_i     : first address of the store
//   stride_i   : address increment per beat
//   addr_o     : address of the next beat to issue after beat 0
//
// Beat 0 is addressed straight from base_i by the caller, so the accumulator
// always runs one beat ahead. The AW-bit adder wraps modulo 2^AW by design.
// -----------------------------------------------------------------------------
module vsu_addr_gen #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW-1:0] stride_i,
  output logic [AW-1:0] addr_o
);

  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] stride_q, stride_d;

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_d    = acc_q;
    stride_d = stride_q;
    if (load_i) begin
      acc_d    = base_i + stride_i;
      stride_d = stride_i;
    end else if (step_i) begin
      acc_d = acc_q + stride_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      stride_q <= '0;
    end else begin
      acc_q    <= acc_d;
      stride_q <= stride_d;
    end
  end

  assign addr_o = acc_q;

endmodule

// File: rtl/vec_store_unit.sv
// -----------------------------------------------------------------------------
// vec_store_unit -- writes one captured vector into a BRAM as a sequence of
// LANES-wide beats at baseAddr, baseAddr+stride, ... (modulo 2^MEM_DEPTH).
//
// Ports:
//   clk    : clock, rising edge
//   RESET  : asynchronous active-low reset, aborts any store silently
//   bus    : vec_store_unit_if.slave (request inputs, BRAM write outputs)
//
// Timing: the edge that accepts start also registers beat 0, so writeEN is
// high the next cycle. Each unstalled WRITE cycle registers the next beat;
// stall sampled high holds the beat counter and registers writeEN low. After
// all BEATS beats have been shown, one DONE cycle pulses WRdone.
//
// Build option: define VSU_MASK_EN to add bus.elemMask. laneWE then follows
// the captured mask bits of each beat and writeEN is their OR; a fully masked
// beat still takes its cycle. Without it laneWE is all ones on every beat.
// -----------------------------------------------------------------------------
module vec_store_unit
  import vsu_pkg::*;
#(
  parameter int NO_OF_ELEM = 16,
  parameter int WORD_SIZE  = 32,
  parameter int MEM_DEPTH  = 9,
  parameter int LANES      = 1
) (
  input logic             clk,
  input logic             RESET,
  vec_store_unit_if.slave bus
);

  localparam int BEATS  = vsu_beats(NO_OF_ELEM, LANES);
  localparam int CNT_W  = vsu_cnt_w(BEATS);
  localparam int BEAT_W = LANES * WORD_SIZE;
  localparam int VEC_W  = NO_OF_ELEM * WORD_SIZE;

  vsu_state_e           state_q, state_d;
  logic [CNT_W-1:0]     beat_q, beat_d;      // next beat to issue
  logic [VEC_W-1:0]     data_q, data_d;      // captured vector
  logic [BEAT_W-1:0]    dout_q, dout_d;
  logic [MEM_DEPTH-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [LANES-1:0]     lane_we_q, lane_we_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 gen_load, gen_step, issue;
  logic [MEM_DEPTH-1:0] gen_addr;
  logic [CNT_W-1:0]     beat_idx;
  logic [BEAT_W-1:0]    src_data;
  logic [MEM_DEPTH-1:0] src_addr;
  logic [LANES-1:0]     src_mask;

`ifdef VSU_MASK_EN
  logic [NO_OF_ELEM-1:0] mask_q, mask_d;
`endif

  vsu_addr_gen #(.AW(MEM_DEPTH)) u_addr_gen (
    .clk      (clk),
    .rst_n    (RESET),
    .load_i   (gen_load),
    .step_i   (gen_step),
    .base_i   (bus.baseAddr),
    .stride_i (bus.stride),
    .addr_o   (gen_addr)
  );

  // Keeps the lane select in range once the counter has reached BEATS.
  assign beat_idx = (beat_q == CNT_W'(BEATS)) ? '0 : beat_q;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    data_d    = data_q;
    dout_d    = dout_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    lane_we_d = '0;
    gen_load  = 1'b0;
    gen_step  = 1'b0;
    issue     = 1'b0;
    src_data  = data_q[32'(beat_idx) * BEAT_W +: BEAT_W];
    src_addr  = gen_addr;
`ifdef VSU_MASK_EN
    mask_d    = mask_q;
    src_mask  = mask_q[32'(beat_idx) * LANES +: LANES];
`else
    src_mask  = '1;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Beat 0 comes straight from the inputs so it is on the BRAM port
          // the cycle after acceptance.
          state_d  = WRITE;
          data_d   = bus.dataIn;
          beat_d   = CNT_W'(1);
          gen_load = 1'b1;
          issue    = 1'b1;
          src_data = bus.dataIn[BEAT_W-1:0];
          src_addr = bus.baseAddr;
`ifdef VSU_MASK_EN
          mask_d   = bus.elemMask;
          src_mask = bus.elemMask[LANES-1:0];
`endif
        end
      end
      WRITE: begin
        if (beat_q == CNT_W'(BEATS)) begin
          state_d = DONE;
          beat_d  = '0;
        end else if (!bus.stall) begin
          issue    = 1'b1;
          gen_step = 1'b1;
          beat_d   = beat_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Data and address only move on a real write, so they hold otherwise.
    if (issue) begin
      lane_we_d = src_mask;
      we_d      = |src_mask;
      if (|src_mask) begin
        dout_d = src_data;
        addr_d = src_addr;
      end
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      // NOTE: the captured vector is cleared as well, so nothing from an
      // aborted store survives the reset.
      data_q    <= '0;
      dout_q    <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      lane_we_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef VSU_MASK_EN
      mask_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      data_q    <= data_d;
      dout_q    <= dout_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      lane_we_q <= lane_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef VSU_MASK_EN
      mask_q    <= mask_d;
`endif
    end
  end

  assign bus.dataOut       = dout_q;
  assign bus.writeAddrBRAM = addr_q;
  assign bus.writeEN       = we_q;
  assign bus.laneWE        = lane_we_q;
  assign bus.busy          = busy_q;
  assign bus.WRdone        = done_q;

endmodule

// File: tb/tb_vec_store_unit.sv
// -----------------------------------------------------------------------------
// tb_vec_store_unit -- scoreboard bench for vec_store_unit.
// dut_a: default parameters (1 lane); dut_b: LANES=4 (128-bit beats).
// Stimulus pushes expected BRAM writes / WRdone pulses (with the cycle they
// must appear in) into a queue; a monitor per DUT pops and compares on every
// cycle that shows writeEN or WRdone. Cycle 0 is the cycle start is accepted.
// Define VSU_MASK_EN for both RTL and bench to exercise the element mask.
// -----------------------------------------------------------------------------
module tb_vec_store_unit;

  localparam int NE = 16;
  localparam int WS = 32;
  localparam int MD = 9;

  logic clk = 1'b0;
  logic RESET;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit            is_done;
    int            cyc;
    logic [MD-1:0] addr;
    logic [127:0]  data;
    logic [3:0]    lanes;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  vec_store_unit_if #(.NO_OF_ELEM(NE), .WORD_SIZE(WS), .MEM_DEPTH(MD), .LANES(1)) ifa ();
  vec_store_unit_if #(.NO_OF_ELEM(NE), .WORD_SIZE(WS), .MEM_DEPTH(MD), .LANES(4)) ifb ();

  vec_store_unit #(.NO_OF_ELEM(NE), .WORD_SIZE(WS), .MEM_DEPTH(MD), .LANES(1)) dut_a (
    .clk(clk), .RESET(RESET), .bus(ifa)
  );
  vec_store_unit #(.NO_OF_ELEM(NE), .WORD_SIZE(WS), .MEM_DEPTH(MD), .LANES(4)) dut_b (
    .clk(clk), .RESET(RESET), .bus(ifb)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Element i = first + i.
  function automatic logic [511:0] mk_vec(input logic [31:0] first);
    logic [511:0] v;
    for (int i = 0; i < NE; i++) v[i*32 +: 32] = first + 32'(i);
    return v;
  endfunction

  // ---------------------------------------------------------------- monitors
  always @(negedge clk) begin
    if (ifa.writeEN || ifa.WRdone) begin
      if (qa.size() == 0) begin
        check("a_spurious_event", {ifa.writeEN, ifa.WRdone}, 2'b00);
      end else begin
        ea = qa.pop_front();
        check("a_cycle", cyc, ea.cyc);
        check("a_wrdone", ifa.WRdone, ea.is_done);
        check("a_writeen", ifa.writeEN, !ea.is_done);
        check("a_busy", ifa.busy, 1'b1);
        if (!ea.is_done) begin
          check("a_addr", ifa.writeAddrBRAM, ea.addr);
          check("a_data", ifa.dataOut, ea.data);
          check("a_lanewe", ifa.laneWE, ea.lanes);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.writeEN || ifb.WRdone) begin
      if (qb.size() == 0) begin
        check("b_spurious_event", {ifb.writeEN, ifb.WRdone}, 2'b00);
      end else begin
        eb = qb.pop_front();
        check("b_cycle", cyc, eb.cyc);
        check("b_wrdone", ifb.WRdone, eb.is_done);
        check("b_writeen", ifb.writeEN, !eb.is_done);
        if (!eb.is_done) begin
          check("b_addr", ifb.writeAddrBRAM, eb.addr);
          check("b_data", ifb.dataOut, eb.data);
          check("b_lanewe", ifb.laneWE, eb.lanes);
        end
      end
    end
  end

  // ------------------------------------------------------- expectation push
  // Beat k appears in cycle s+1+k, plus stall_len once k reaches stall_at;
  // WRdone in cycle s+17+stall_len. Masked beats produce no write.
  task automatic push_a(input int s, input logic [MD-1:0] base, input logic [MD-1:0] stride,
                        input logic [511:0] vec, input logic [15:0] mask,
                        input int stall_at, input int stall_len,
                        input int n_issue, input bit with_done);
    exp_t e;
    for (int k = 0; k < n_issue; k++) begin
      e.is_done = 1'b0;
      e.cyc     = s + 1 + k + ((k >= stall_at) ? stall_len : 0);
      e.addr    = base + MD'(k) * stride;
      e.data    = 128'(vec[k*32 +: 32]);
      e.lanes   = 4'b0001;
      if (mask[k]) qa.push_back(e);
    end
    if (with_done) begin
      e.is_done = 1'b1;
      e.cyc     = s + 17 + stall_len;
      e.addr    = '0;
      e.data    = '0;
      e.lanes   = '0;
      qa.push_back(e);
    end
  endtask

  task automatic start_a(input logic [MD-1:0] base, input logic [MD-1:0] stride,
                         input logic [511:0] vec, input logic [15:0] mask,
                         input int stall_at, input int stall_len,
                         input int n_issue, input bit with_done, output int s);
    @(negedge clk);
    ifa.baseAddr = base;
    ifa.stride   = stride;
    ifa.dataIn   = vec;
`ifdef VSU_MASK_EN
    ifa.elemMask = mask;
`endif
    ifa.start    = 1'b1;
    s = cyc;
    push_a(s, base, stride, vec, mask, stall_at, stall_len, n_issue, with_done);
    @(negedge clk);
    // Scramble the inputs: the store must use only what was captured.
    ifa.start    = 1'b0;
    ifa.dataIn   = ~vec;
    ifa.baseAddr = ~base;
    ifa.stride   = stride + 9'd3;
`ifdef VSU_MASK_EN
    ifa.elemMask = ~mask;
`endif
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while ((qa.size() != 0 || qb.size() != 0) && i < 200) begin
      @(negedge clk);
      i++;
    end
    check(name, qa.size() + qb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // -------------------------------------------------------------- stimulus
  int s1, s2, s3, s5, s6, sb;
`ifdef VSU_MASK_EN
  int s4;
`endif
  logic [511:0] vb;

  initial begin
    RESET        = 1'b0;
    ifa.start    = 1'b0;
    ifa.stall    = 1'b0;
    ifa.dataIn   = '0;
    ifa.baseAddr = '0;
    ifa.stride   = '0;
    ifb.start    = 1'b0;
    ifb.stall    = 1'b0;
    ifb.dataIn   = '0;
    ifb.baseAddr = '0;
    ifb.stride   = '0;
`ifdef VSU_MASK_EN
    ifa.elemMask = '0;
    ifb.elemMask = '1;
`endif
    repeat (3) @(negedge clk);

    check("rst_dataout", ifa.dataOut, 0);
    check("rst_addr", ifa.writeAddrBRAM, 0);
    check("rst_writeen", ifa.writeEN, 0);
    check("rst_lanewe", ifa.laneWE, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_wrdone", ifa.WRdone, 0);
    check("rst_b_dataout", ifb.dataOut, 0);
    RESET = 1'b1;

    // Basic store, start ignored while busy, start held through DONE.
    start_a(9'h010, 9'h001, mk_vec(32'hA0), 16'hFFFF, 99, 0, 16, 1'b1, s1);
    wait_to(s1 + 5);
    ifa.start    = 1'b1;
    ifa.baseAddr = 9'h1AA;
    @(negedge clk);
    ifa.start = 1'b0;
    wait_to(s1 + 10);
    check("a_busy_mid", ifa.busy, 1'b1);
    wait_to(s1 + 17);
    // Wrapping store, start raised in the DONE cycle: accepted in cycle 18.
    ifa.baseAddr = 9'h1FE;
    ifa.stride   = 9'h001;
    ifa.dataIn   = mk_vec(32'hB0);
`ifdef VSU_MASK_EN
    ifa.elemMask = 16'hFFFF;
`endif
    ifa.start    = 1'b1;
    s2 = s1 + 18;
    push_a(s2, 9'h1FE, 9'h001, mk_vec(32'hB0), 16'hFFFF, 99, 0, 16, 1'b1);
    @(negedge clk);
    @(negedge clk);
    ifa.start  = 1'b0;
    ifa.dataIn = '0;
    drain("a_drain_basic_wrap");
    check("a_hold_addr", ifa.writeAddrBRAM, 9'h00D);
    check("a_hold_data", ifa.dataOut, 32'hBF);
    check("a_idle_busy", ifa.busy, 1'b0);

    // Stall for 3 cycles while beat 5 is pending.
    start_a(9'h040, 9'h003, mk_vec(32'hC000_0000), 16'hFFFF, 5, 3, 16, 1'b1, s3);
    wait_to(s3 + 5);
    ifa.stall = 1'b1;
    wait_to(s3 + 7);
    check("a_stall_we_low", ifa.writeEN, 1'b0);
    wait_to(s3 + 8);
    ifa.stall = 1'b0;
    drain("a_drain_stall");

`ifdef VSU_MASK_EN
    // Upper eight elements masked: no write, data/address hold at beat 7.
    start_a(9'h080, 9'h001, mk_vec(32'h55), 16'h00FF, 99, 0, 16, 1'b1, s4);
    drain("a_drain_mask");
    check("a_mask_hold_data", ifa.dataOut, 32'h5C);
    check("a_mask_hold_addr", ifa.writeAddrBRAM, 9'h087);
`endif

    // Reset while beat 8 is on the port: everything clears, no WRdone.
    start_a(9'h050, 9'h001, mk_vec(32'hD0), 16'hFFFF, 99, 0, 9, 1'b0, s5);
    wait_to(s5 + 9);
    #1 RESET = 1'b0;
    #1;
    check("abort_dataout", ifa.dataOut, 0);
    check("abort_addr", ifa.writeAddrBRAM, 0);
    check("abort_writeen", ifa.writeEN, 0);
    check("abort_lanewe", ifa.laneWE, 0);
    check("abort_busy", ifa.busy, 0);
    check("abort_wrdone", ifa.WRdone, 0);
    repeat (3) @(negedge clk);
    check("abort_beats_seen", qa.size(), 0);
    RESET = 1'b1;
    start_a(9'h060, 9'h002, mk_vec(32'hE0), 16'hFFFF, 99, 0, 16, 1'b1, s6);
    drain("a_drain_after_abort");

    // Four lanes: 128-bit beats at 0x100, 0x104, 0x108, 0x10C.
    vb = mk_vec(32'h1000);
    @(negedge clk);
    ifb.baseAddr = 9'h100;
    ifb.stride   = 9'h004;
    ifb.dataIn   = vb;
    ifb.start    = 1'b1;
    sb = cyc;
    for (int k = 0; k < 4; k++) begin
      eb.is_done = 1'b0;
      eb.cyc     = sb + 1 + k;
      eb.addr    = 9'h100 + MD'(4 * k);
      eb.data    = vb[k*128 +: 128];
      eb.lanes   = 4'hF;
      qb.push_back(eb);
    end
    eb.is_done = 1'b1;
    eb.cyc     = sb + 5;
    eb.addr    = '0;
    eb.data    = '0;
    eb.lanes   = '0;
    qb.push_back(eb);
    @(negedge clk);
    ifb.start  = 1'b0;
    ifb.dataIn = '0;
    drain("b_drain_lanes");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vec_store_unit.md
VEC_STORE_UNIT -- requirements
Module: vec_store_unit

Interface
REQ-001 SHALL have parameter NO_OF_ELEM, default 16, meaning vector elements per store.
REQ-002 SHALL have parameter WORD_SIZE, default 32, meaning bits per element.
REQ-003 SHALL have parameter MEM_DEPTH, default 9, meaning BRAM address width.
REQ-004 SHALL have parameter LANES, default 1, meaning elements written per BRAM beat; NO_OF_ELEM % LANES == 0.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port RESET, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, store request; sampled only in IDLE.
REQ-008 SHALL have port stall, input, 1, BRAM back-pressure; freezes the beat sequence.
REQ-009 SHALL have port dataIn, input, NO_OF_ELEM x WORD_SIZE, vector from the processing elements.
REQ-010 SHALL have port baseAddr, input, MEM_DEPTH, first BRAM address.
REQ-011 SHALL have port stride, input, MEM_DEPTH, address increment per beat.
REQ-012 SHALL have port elemMask, input, NO_OF_ELEM, per-element write enable; present only with VSU_MASK_EN.
REQ-013 SHALL have port dataOut, output, LANES*WORD_SIZE, BRAM write data.
REQ-014 SHALL have port writeAddrBRAM, output, MEM_DEPTH, BRAM write address.
REQ-015 SHALL have port writeEN, output, 1, BRAM write strobe.
REQ-016 SHALL have port laneWE, output, LANES, per-lane write enable.
REQ-017 SHALL have ports busy and WRdone, output, 1 each: operation in progress; one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, WRITE, DONE; IDLE->WRITE on start, WRITE->DONE after last beat issued, DONE->IDLE unconditionally.
REQ-019 SHALL capture dataIn, baseAddr, stride (and elemMask) into registers on the cycle start is accepted; later input changes SHALL NOT affect the operation.
REQ-020 SHALL issue BEATS = NO_OF_ELEM/LANES beats; beat k drives dataOut lane j = element k*LANES+j, writeAddrBRAM = baseAddr + k*stride modulo 2^MEM_DEPTH (wraps silently).
REQ-021 SHALL register all outputs; first writeEN high the cycle after start is accepted; unstalled store takes BEATS cycles plus one DONE cycle.
REQ-022 SHALL, when stall is high in WRITE, drive writeEN=0, laneWE=0 and hold the beat counter; the held beat issues on the first cycle after stall falls.
REQ-023 SHALL pulse WRdone for exactly one cycle in DONE; busy SHALL be high in WRITE and DONE, low in IDLE.
REQ-024 SHALL ignore start while busy; start in DONE is ignored, start in the following IDLE cycle is accepted.
REQ-025 SHALL hold dataOut and writeAddrBRAM at last values when writeEN is low.

Reset
REQ-026 SHALL, on RESET low, immediately enter IDLE and clear dataOut, writeAddrBRAM, writeEN, laneWE, busy, WRdone, beat counter and captured registers to 0, aborting any operation without a WRdone pulse.

Configuration
REQ-027 SHALL, with VSU_MASK_EN defined, add elemMask and drive laneWE[j] = captured mask bit for the beat's element; writeEN = OR of laneWE; fully masked beats still consume one cycle.
REQ-028 SHALL, without VSU_MASK_EN, omit elemMask and drive laneWE all-ones whenever writeEN is high.

Structure
REQ-029 SHALL place the state enum and BEATS/beat-counter-width helper in shared package vsu_pkg.
REQ-030 SHALL contain one sub-module vsu_addr_gen (base/stride accumulator with modulo wrap).

Verification
REQ-031 Defaults, base=0x010, stride=1, elements 0..15 = 0xA0..0xAF, start -> writes addr 0x010..0x01F data 0xA0..0xAF, WRdone pulse on cycle 17.
REQ-032 LANES=4, base=0x100, stride=4 -> 4 beats at 0x100,0x104,0x108,0x10C, each 128-bit beat holding elements 4k..4k+3.
REQ-033 base=0x1FE, stride=1 -> addresses 0x1FE,0x1FF,0x000,...,0x00D.
REQ-034 stall high for 3 cycles during beat 5 -> writeEN low 3 cycles, beat 5 reissued unchanged, WRdone delayed 3 cycles.
REQ-035 VSU_MASK_EN, mask=0x00FF -> writeEN high beats 0..7 only, low beats 8..15, WRdone still on cycle 17.
REQ-036 RESET asserted at beat 8 -> all outputs 0 immediately, no WRdone; new start after release writes from beat 0.
